// File: rtl/config_pkg.sv
// ============================================================================
// Module      : config_pkg
// Description : Shared types, field offsets and packet builder for the
//               PE-array configuration injector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package config_pkg;

    localparam int HDR_W          = 20;
    localparam int CNT_W          = 7;
    localparam int COORD_W        = 5;
    localparam int OFF_HDR_MSB    = 63;
    localparam int OFF_HDR_LSB    = 44;
    localparam int OFF_SAMPLER    = 40;
    localparam int OFF_DESIGNATOR = 36;
    localparam int OFF_INSTR      = 32;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        logic [3:0]         sampler;
        logic [3:0]         designator;
        logic [3:0]         instruction;
        logic [31:0]        internal;
    } cfg_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

    function automatic logic [63:0] build_packet(input logic [HDR_W-1:0] hdr,
                                                 input cfg_req_t          req);
        logic [63:0] pkt;
        pkt                            = '0;
        pkt[OFF_HDR_MSB:OFF_HDR_LSB]   = hdr;
        pkt[OFF_SAMPLER +: 4]          = req.sampler;
        pkt[OFF_DESIGNATOR +: 4]       = req.designator;
        pkt[OFF_INSTR +: 4]            = req.instruction;
        pkt[OFF_INSTR-1:0]             = req.internal;
        return pkt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/route_header_encoder.sv
// ============================================================================
// Module      : route_header_encoder
// Description : (row, col) -> XY route header (col east ones, row south
//               zeros, terminal one) and the drain count 2*(row+col+1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module route_header_encoder
    import config_pkg::*;
(
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    output logic [HDR_W-1:0]   o_header,
    output logic [CNT_W-1:0]   o_drain
);

    logic [COORD_W:0] w_term;

    assign w_term  = {1'b0, i_row} + {1'b0, i_col};
    // Two cycles per hop: each switch registers then acts on the packet.
    assign o_drain = {w_term, 1'b0} + CNT_W'(2);

    always_comb begin
        o_header = '0;
        for (int i = 0; i < HDR_W; i++) begin
            o_header[HDR_W-1-i] = (6'(i) < {1'b0, i_col}) || (6'(i) == w_term);
        end
    end

endmodule

`default_nettype wire

// File: rtl/config_injector.sv
// ============================================================================
// Module      : config_injector
// Description : Edge-side transmitter streaming routed 64-bit config packets
//               into the corner switch. Optional CONFIG_INJECTOR_BOUNDS_CHECK_EN
//               drops out-of-range requests and pulses o_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_injector
    import config_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] i_row,
    input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] i_col,
    input  logic [3:0]                            i_port_sampler,
    input  logic [3:0]                            i_out_designator,
    input  logic [3:0]                            i_instruction,
    input  logic [31:0]                           i_internal,
    output logic [63:0]                           o_config,
    output logic                                  o_load,
    output logic                                  o_configuration_mux,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_err
);

    cfg_state_e          r_state;
    cfg_state_e          w_next;
    logic [CNT_W-1:0]    r_cnt;
    cfg_req_t            r_req;
    cfg_req_t            w_req;
    logic                w_ready;
    logic                w_accept;
    logic                w_drop;
    logic [HDR_W-1:0]    w_header;
    logic [CNT_W-1:0]    w_drain;

    always_comb begin
        w_req             = '0;
        w_req.row         = COORD_W'(i_row);
        w_req.col         = COORD_W'(i_col);
        w_req.sampler     = i_port_sampler;
        w_req.designator  = i_out_designator;
        w_req.instruction = i_instruction;
        w_req.internal    = i_internal;
    end

    // Ready is a pure state decode; reset gating keeps it low during reset.
    assign w_ready  = (r_state == IDLE) || ((r_state == DRAIN) && (r_cnt == '0));
    assign o_ready  = w_ready & ~reset;
    assign w_accept = i_valid & w_ready;

`ifdef CONFIG_INJECTOR_BOUNDS_CHECK_EN
    logic r_err;

    assign w_drop = (w_req.row >= COORD_W'(ROWS)) || (w_req.col >= COORD_W'(COLS));
    assign o_err  = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & w_drop;
        end
    end
`else
    assign w_drop = 1'b0;
    assign o_err  = 1'b0;
`endif

    route_header_encoder u_encoder (
        .i_row    (r_req.row),
        .i_col    (r_req.col),
        .o_header (w_header),
        .o_drain  (w_drain)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_drop) w_next = SEND;
            end
            SEND: begin
                w_next = DRAIN;
            end
            DRAIN: begin
                if (r_cnt == '0) begin
                    w_next = (w_accept && !w_drop) ? SEND : DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_drop) r_req <= w_req;
            if (r_state == SEND) begin
                r_cnt <= w_drain - CNT_W'(1);
            end else if ((r_state == DRAIN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_config            = (r_state == SEND) ? build_packet(w_header, r_req) : 64'd0;
    assign o_load              = (r_state == SEND) || (r_state == DRAIN);
    assign o_busy              = (r_state != IDLE);
    assign o_done              = (r_state == DONE);
    assign o_configuration_mux = 1'b0;

endmodule

`default_nettype wire
